// File: rtl/display_page_sequencer.sv
// Drives one of PAGES digit pages onto the scan-driver bus, chosen either by
// direct select or by timed auto-rotation that skips disabled pages.
module display_page_sequencer #(
  parameter int unsigned          PAGES      = 4,
  parameter int unsigned          DIGITS     = 4,
  parameter int unsigned          DIGIT_W    = 4,
  parameter int unsigned          DWELL      = 5,
  parameter logic [DIGIT_W-1:0]   BLANK_CODE = 4'hF,
  localparam int unsigned         PW         = $clog2(PAGES),
  localparam int unsigned         DW         = DIGITS * DIGIT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                auto_mode,
  input  logic                hold,
  input  logic [PW-1:0]       sel_page,
  input  logic [PAGES-1:0]    page_en,
  input  logic [PAGES-1:0]    blink_mask,
  input  logic [PAGES*DW-1:0] page_data,
  output logic [DW-1:0]       out_digits,
  output logic [PW-1:0]       page_idx,
  output logic                page_changed,
  output logic                all_off
);

  localparam int unsigned     DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [PW:0]     PAGES_W    = (PW + 1)'(PAGES);
  localparam logic [DW-1:0]   BLANK_ALL  = {DIGITS{BLANK_CODE}};

  typedef enum logic [1:0] {
    S_MANUAL,
    S_DWELL,
    S_SEEK
  } state_t;

  state_t          state, state_n;
  logic [DCW-1:0]  dwell_cnt, dwell_n;
  logic [PW-1:0]   cand, cand_n;
  logic [PW-1:0]   idx_n;
  logic            blink_phase, blink_n;
  logic            all_off_n;
  logic [DW-1:0]   out_n;

  function automatic logic [PW-1:0] next_page(input logic [PW-1:0] p);
    return (p == PW'(PAGES - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_n   = state;
    dwell_n   = dwell_cnt;
    cand_n    = cand;
    idx_n     = page_idx;
    blink_n   = blink_phase ^ tick;
    all_off_n = auto_mode && (page_en == '0);

    if (!auto_mode) begin
      state_n = S_MANUAL;
      if ({1'b0, sel_page} < PAGES_W) idx_n = sel_page;
    end else begin
      case (state)
        S_MANUAL: begin
          state_n = S_DWELL;
          dwell_n = '0;
        end
        S_DWELL: begin
          // With nothing enabled the dwell count is frozen until a page returns.
          if (!all_off_n) begin
            if (!page_en[page_idx]) begin
              state_n = S_SEEK;
              cand_n  = next_page(page_idx);
            end else if (tick && !hold) begin
              if (dwell_cnt == DWELL_LAST) begin
                dwell_n = '0;
                state_n = S_SEEK;
                cand_n  = next_page(page_idx);
              end else begin
                dwell_n = dwell_cnt + 1'b1;
              end
            end
          end
        end
        S_SEEK: begin
          if (all_off_n) begin
            state_n = S_DWELL;
          end else if (page_en[cand]) begin
            idx_n   = cand;
            state_n = S_DWELL;
            dwell_n = '0;
          end else begin
            cand_n = next_page(cand);
          end
        end
        default: state_n = S_MANUAL;
      endcase
    end

    out_n = page_data[idx_n*DW +: DW];
    if (all_off_n || (blink_n && blink_mask[idx_n])) out_n = BLANK_ALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_MANUAL;
      dwell_cnt    <= '0;
      cand         <= '0;
      blink_phase  <= 1'b0;
      page_idx     <= '0;
      out_digits   <= BLANK_ALL;
      page_changed <= 1'b0;
      all_off      <= 1'b0;
    end else begin
      state        <= state_n;
      dwell_cnt    <= dwell_n;
      cand         <= cand_n;
      blink_phase  <= blink_n;
      page_idx     <= idx_n;
      out_digits   <= out_n;
      page_changed <= (idx_n != page_idx);
      all_off      <= all_off_n;
    end
  end

endmodule

// File: tb/tb_display_page_sequencer.sv
// Scoreboard bench for display_page_sequencer: directed stimulus pushes expected
// display state and page-change strobes; a negedge monitor pops and compares.
module tb_display_page_sequencer;

  logic        clk = 1'b0;
  logic        rst, tick, auto_mode, hold;
  logic [1:0]  sel_page;
  logic [3:0]  page_en, blink_mask;
  logic [63:0] page_data;
  logic [15:0] out_digits;
  logic [1:0]  page_idx;
  logic        page_changed, all_off;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          stamp;
    logic [1:0]  idx;
    logic [15:0] dig;
    logic        aoff;
    string       name;
  } exp_t;

  exp_t       eq[$];
  logic [1:0] sq[$];

  display_page_sequencer #(
    .PAGES     (4),
    .DIGITS    (4),
    .DIGIT_W   (4),
    .DWELL     (2),
    .BLANK_CODE(4'hF)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .auto_mode   (auto_mode),
    .hold        (hold),
    .sel_page    (sel_page),
    .page_en     (page_en),
    .blink_mask  (blink_mask),
    .page_data   (page_data),
    .out_digits  (out_digits),
    .page_idx    (page_idx),
    .page_changed(page_changed),
    .all_off     (all_off)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Expectation for the state registered by the most recent clock edge.
  task automatic expect_now(input string name, input logic [1:0] idx,
                            input logic [15:0] dig, input logic aoff);
    exp_t e;
    e.stamp = cyc;
    e.idx   = idx;
    e.dig   = dig;
    e.aoff  = aoff;
    e.name  = name;
    eq.push_back(e);
  endtask

  task automatic expect_strobe(input logic [1:0] idx);
    sq.push_back(idx);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] s;
    if (page_changed === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected page_changed at cycle %0d, page_idx=%0d, required no strobe",
                 cyc, page_idx);
      end else begin
        s = sq.pop_front();
        if (page_idx !== s) begin
          errors++;
          $display("FAIL strobe: page_changed with page_idx=%0d, required %0d", page_idx, s);
        end
      end
    end
    while (eq.size() > 0 && eq[0].stamp <= cyc) begin
      e = eq.pop_front();
      checks++;
      if (e.stamp != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.stamp, cyc);
      end else if (page_idx !== e.idx || out_digits !== e.dig || all_off !== e.aoff) begin
        errors++;
        $display("FAIL %s: got idx=%0d dig=%h all_off=%b, required idx=%0d dig=%h all_off=%b",
                 e.name, page_idx, out_digits, all_off, e.idx, e.dig, e.aoff);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    auto_mode  = 1'b0;
    hold       = 1'b0;
    sel_page   = 2'd0;
    page_en    = 4'b1111;
    blink_mask = 4'b0000;
    page_data  = {16'h9ABC, 16'h1234, 16'h5678, 16'h0A0B};

    step();
    step();
    expect_now("reset", 2'd0, 16'hFFFF, 1'b0);

    // Manual select: one-cycle latency, reset values visible until then.
    rst      = 1'b0;
    sel_page = 2'd2;
    step();
    expect_now("manual_p2", 2'd2, 16'h1234, 1'b0);
    expect_strobe(2'd2);
    step();
    expect_now("manual_p2_hold", 2'd2, 16'h1234, 1'b0);

    // Blink on page 1, page 0 with mask clear stays lit.
    sel_page   = 2'd1;
    blink_mask = 4'b0010;
    step();
    expect_now("blink_p1_on", 2'd1, 16'h5678, 1'b0);
    expect_strobe(2'd1);
    tick_step();
    expect_now("blink_p1_dark", 2'd1, 16'hFFFF, 1'b0);
    step();
    expect_now("blink_p1_dark2", 2'd1, 16'hFFFF, 1'b0);
    tick_step();
    expect_now("blink_p1_lit", 2'd1, 16'h5678, 1'b0);
    sel_page = 2'd0;
    tick_step();
    expect_now("blink_p0_phase1", 2'd0, 16'h0A0B, 1'b0);
    expect_strobe(2'd0);
    tick_step();
    expect_now("blink_p0_phase0", 2'd0, 16'h0A0B, 1'b0);
    blink_mask = 4'b0000;

    // Auto rotation over pages 0,1,3 with page 2 skipped.
    auto_mode = 1'b1;
    page_en   = 4'b1011;
    step();
    expect_now("auto_enter", 2'd0, 16'h0A0B, 1'b0);
    tick_step();
    expect_now("rot_p0_t1", 2'd0, 16'h0A0B, 1'b0);
    tick_step();
    expect_now("rot_p0_expire", 2'd0, 16'h0A0B, 1'b0);
    step();
    expect_now("rot_p1", 2'd1, 16'h5678, 1'b0);
    expect_strobe(2'd1);
    tick_step();
    expect_now("rot_p1_t1", 2'd1, 16'h5678, 1'b0);
    tick_step();
    expect_now("rot_p1_expire", 2'd1, 16'h5678, 1'b0);
    step();
    expect_now("rot_skip_p2", 2'd1, 16'h5678, 1'b0);
    step();
    expect_now("rot_p3", 2'd3, 16'h9ABC, 1'b0);
    expect_strobe(2'd3);
    tick_step();
    tick_step();
    expect_now("rot_p3_expire", 2'd3, 16'h9ABC, 1'b0);
    step();
    expect_now("rot_wrap_p0", 2'd0, 16'h0A0B, 1'b0);
    expect_strobe(2'd0);

    // Hold freezes the dwell count but keeps it.
    tick_step();
    expect_now("hold_pre_t1", 2'd0, 16'h0A0B, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_step();
      expect_now("hold_frozen", 2'd0, 16'h0A0B, 1'b0);
    end
    hold = 1'b0;
    tick_step();
    expect_now("hold_release_expire", 2'd0, 16'h0A0B, 1'b0);
    step();
    expect_now("hold_release_p1", 2'd1, 16'h5678, 1'b0);
    expect_strobe(2'd1);

    // Everything disabled, then a single page returns.
    page_en = 4'b0000;
    step();
    expect_now("all_off", 2'd1, 16'hFFFF, 1'b1);
    tick_step();
    expect_now("all_off_tick", 2'd1, 16'hFFFF, 1'b1);
    page_en = 4'b0100;
    step();
    expect_now("all_off_resume", 2'd1, 16'h5678, 1'b0);
    step();
    expect_now("resume_p2", 2'd2, 16'h1234, 1'b0);
    expect_strobe(2'd2);

    // Sole enabled page is current: full seek wraps back, no strobe.
    tick_step();
    tick_step();
    for (int i = 0; i < 5; i++) begin
      expect_now("sole_page", 2'd2, 16'h1234, 1'b0);
      step();
    end
    expect_now("sole_page_done", 2'd2, 16'h1234, 1'b0);

    // Leaving auto on the expiring tick: manual select wins.
    page_en = 4'b1111;
    tick_step();
    expect_now("pre_switch_t1", 2'd2, 16'h1234, 1'b0);
    auto_mode = 1'b0;
    sel_page  = 2'd0;
    tick_step();
    expect_now("switch_manual", 2'd0, 16'h0A0B, 1'b0);
    expect_strobe(2'd0);
    step();
    expect_now("switch_manual_settle", 2'd0, 16'h0A0B, 1'b0);

    // Reset mid-seek abandons it; auto restarts from page 0 via MANUAL.
    auto_mode = 1'b1;
    step();
    page_en = 4'b1000;
    step();
    step();
    rst = 1'b1;
    step();
    expect_now("reset_mid_seek", 2'd0, 16'hFFFF, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_now("post_reset_seek", 2'd0, 16'h0A0B, 1'b0);
    end
    step();
    expect_now("post_reset_p3", 2'd3, 16'h9ABC, 1'b0);
    expect_strobe(2'd3);

    step();
    step();
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL strobe_drain: %0d expected strobes never seen, required 0", sq.size());
    end
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL exp_drain: %0d expectations left, required 0", eq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
